// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encodings and default sizing for the elevator car
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 8;
  localparam int DEF_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_t;

endpackage

// File: rtl/elevator_car_controller_if.sv
// rtl/elevator_car_controller_if.sv - call/floor interface between car controller and direction/floor-check logic
interface elevator_car_controller_if #(
  parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEF_FLOOR_W
) ();

  logic [NUM_FLOORS-1:0] call_req;
  logic                  go_up;
  logic                  open;
  logic [NUM_FLOORS-1:0] floors_called;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  door_open;
  logic                  moving;
  logic                  dir_up;

  // Car controller side: owns the pending calls and the car position.
  modport master (
    input  call_req,
    input  go_up,
    input  open,
    output floors_called,
    output current_floor,
    output door_open,
    output moving,
    output dir_up
  );

  // Direction / floor-check side.
  modport slave (
    output call_req,
    output go_up,
    output open,
    input  floors_called,
    input  current_floor,
    input  door_open,
    input  moving,
    input  dir_up
  );

endinterface

// File: rtl/decoder8.sv
// rtl/decoder8.sv - 3-to-8 one-hot decoder
module decoder8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // One bit set at the selected position.
  always_comb begin
    onehot = 8'b0000_0001 << sel;
  end

endmodule

// File: rtl/elev_countdown.sv
// rtl/elev_countdown.sv - loadable saturating down-counter with zero flag
module elev_countdown #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Load wins over decrement; the count holds at zero rather than wrapping.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en && (value_q != '0)) begin
      value_d = value_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero = (value_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// rtl/elevator_car_controller.sv - car-side call latch, floor register and IDLE/MOVING/DOOR_OPEN sequencer
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_W       = DEF_FLOOR_W,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  elevator_car_controller_if.master bus
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);

  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state_q;
  state_t                state_d;
  logic [NUM_FLOORS-1:0] floors_called_q;
  logic [NUM_FLOORS-1:0] floors_called_d;
  logic [FLOOR_W-1:0]    current_floor_q;
  logic [FLOOR_W-1:0]    current_floor_d;
  logic                  dir_up_q;
  logic                  dir_up_d;

  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] clr;
  logic                  call_here;
  logic                  travel_load;
  logic                  travel_zero;
  logic                  door_load;
  logic                  door_zero;

  // One-hot mask of the floor the car is standing at.
  generate
    if (NUM_FLOORS == 8) begin : g_dec8
      decoder8 u_floor_dec (
        .sel    (current_floor_q),
        .onehot (here_mask)
      );
    end else begin : g_dec_generic
      assign here_mask = NUM_FLOORS'(1) << current_floor_q;
    end
  endgenerate

  assign call_here = bus.call_req[current_floor_q];

  elev_countdown #(
    .WIDTH (TRAVEL_W)
  ) u_travel_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (travel_load),
    .load_val (TRAVEL_LOAD),
    .en       (state_q == ST_MOVING),
    .zero     (travel_zero)
  );

  elev_countdown #(
    .WIDTH (DOOR_W)
  ) u_door_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (door_load),
    .load_val (DOOR_LOAD),
    .en       (state_q == ST_DOOR),
    .zero     (door_zero)
  );

  // Next-state, floor stepping, timer loads and the call-clear mask.
  always_comb begin
    state_d         = state_q;
    current_floor_d = current_floor_q;
    dir_up_d        = dir_up_q;
    travel_load     = 1'b0;
    door_load       = 1'b0;
    clr             = '0;

    case (state_q)
      ST_IDLE: begin
        if (floors_called_q != '0) begin
          // A call at this floor is served before any travel decision.
          if (bus.open) begin
            state_d   = ST_DOOR;
            door_load = 1'b1;
            clr       = here_mask;
          end else begin
            state_d     = ST_MOVING;
            dir_up_d    = bus.go_up;
            travel_load = 1'b1;
          end
        end
      end

      ST_MOVING: begin
        if (travel_zero) begin
          state_d = ST_IDLE;
          // At the shaft ends the car stays put instead of wrapping around.
          if (dir_up_q && (current_floor_q != TOP_FLOOR)) begin
            current_floor_d = current_floor_q + FLOOR_W'(1);
          end else if (!dir_up_q && (current_floor_q != '0)) begin
            current_floor_d = current_floor_q - FLOOR_W'(1);
          end
        end
      end

      ST_DOOR: begin
        // Presses for this floor reopen the door instead of being latched.
        clr = here_mask;
        if (call_here) begin
          door_load = 1'b1;
        end else if (door_zero) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    floors_called_d = (floors_called_q | bus.call_req) & ~clr;
  end

  // State, pending calls, position and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      floors_called_q <= '0;
      current_floor_q <= '0;
      dir_up_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      floors_called_q <= floors_called_d;
      current_floor_q <= current_floor_d;
      dir_up_q        <= dir_up_d;
    end
  end

  assign bus.floors_called = floors_called_q;
  assign bus.current_floor = current_floor_q;
  assign bus.door_open     = (state_q == ST_DOOR);
  assign bus.moving        = (state_q == ST_MOVING);
  assign bus.dir_up        = dir_up_q;

endmodule
